// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns / InvMixColumns engine: accepts one 128-bit state,
// rewrites it in place COLS_PER_CYCLE columns per clock, then holds the result.
module mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1,
    parameter bit INV_EN         = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_param
            $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [2:0] STEP   = 3'(COLS_PER_CYCLE);

    logic [1:0]   r_state;
    logic [1:0]   r_cnt;
    logic         r_mode;
    logic [127:0] r_work;
    logic [127:0] w_next_work;
    logic         w_last;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] fwd_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] d0, d1, d2, d3;
        a0 = col[31:24]; a1 = col[23:16]; a2 = col[15:8]; a3 = col[7:0];
        d0 = xtime(a0); d1 = xtime(a1); d2 = xtime(a2); d3 = xtime(a3);
        return {d0 ^ (d1 ^ a1) ^ a2 ^ a3,
                a0 ^ d1 ^ (d2 ^ a2) ^ a3,
                a0 ^ a1 ^ d2 ^ (d3 ^ a3),
                (d0 ^ a0) ^ a1 ^ a2 ^ d3};
    endfunction

    // Multiples 9, b, d, e built from the 2x/4x/8x xtime chain of each byte.
    function automatic logic [31:0] inv_col(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int r = 0; r < 4; r++) begin
            a[r]  = col[31-8*r -: 8];
            x2    = xtime(a[r]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[r] = x8 ^ a[r];
            mb[r] = x8 ^ x2 ^ a[r];
            md[r] = x8 ^ x4 ^ a[r];
            me[r] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    always_comb begin
        w_next_work = r_work;
        for (int c = 0; c < 4; c++) begin
            if (c >= int'(r_cnt) && c < int'(r_cnt) + COLS_PER_CYCLE) begin
                w_next_work[127-32*c -: 32] = r_mode ? inv_col(r_work[127-32*c -: 32])
                                                     : fwd_col(r_work[127-32*c -: 32]);
            end
        end
    end

    assign w_last = (({1'b0, r_cnt} + STEP) == 3'd4);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 2'd0;
            r_mode  <= 1'b0;
            r_work  <= 128'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_work  <= in_data;
                        r_mode  <= in_mode & INV_EN;
                        r_cnt   <= 2'd0;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_work <= w_next_work;
                    if (w_last) begin
                        r_cnt   <= 2'd0;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + STEP[1:0];
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_BUSY) || (r_state == S_DONE);
    assign out_data  = r_work;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed bench for mix_columns_seq: four instances cover column widths 1/2/4
// and the forward-only build against hand-computed AES column vectors.
module tb_mix_columns_seq;

    logic         clk;
    logic         reset;
    logic         iv   [4];
    logic [127:0] idat [4];
    logic         im   [4];
    logic         ordy [4];
    logic         iry  [4];
    logic         ov   [4];
    logic [127:0] od   [4];
    logic         bsy  [4];

    int n_cmp;
    int n_err;

    localparam logic [127:0] V1_IN   = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] V1_OUT  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] FIPS_IN = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    localparam logic [127:0] FIPS_OUT= 128'h046681e5_e0cb199a_48f8d37a_2806264c;
    localparam logic [127:0] D4_IN   = 128'hd4d4d4d5_d4d4d4d5_d4d4d4d5_d4d4d4d5;
    localparam logic [127:0] D4_OUT  = 128'hd5d5d7d6_d5d5d7d6_d5d5d7d6_d5d5d7d6;

    mix_columns_seq #(.COLS_PER_CYCLE(1), .INV_EN(1'b1)) u_c1 (
        .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(iry[0]), .in_data(idat[0]),
        .in_mode(im[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .busy(bsy[0]));
    mix_columns_seq #(.COLS_PER_CYCLE(2), .INV_EN(1'b1)) u_c2 (
        .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(iry[1]), .in_data(idat[1]),
        .in_mode(im[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .busy(bsy[1]));
    mix_columns_seq #(.COLS_PER_CYCLE(4), .INV_EN(1'b1)) u_c4 (
        .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(iry[2]), .in_data(idat[2]),
        .in_mode(im[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]), .busy(bsy[2]));
    mix_columns_seq #(.COLS_PER_CYCLE(1), .INV_EN(1'b0)) u_fwd (
        .clk(clk), .reset(reset), .in_valid(iv[3]), .in_ready(iry[3]), .in_data(idat[3]),
        .in_mode(im[3]), .out_valid(ov[3]), .out_ready(ordy[3]), .out_data(od[3]), .busy(bsy[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Push one block, measure cycles to out_valid, then consume the result.
    task automatic run_block(input int d, input logic [127:0] data, input logic mode,
                             input int exp_lat, output logic [127:0] res);
        int lat;
        @(negedge clk);
        idat[d] = data;
        im[d]   = mode;
        iv[d]   = 1'b1;
        @(posedge clk); #1;
        iv[d] = 1'b0;
        lat = 0;
        while (!ov[d] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 128'(lat), 128'(exp_lat));
        res = od[d];
        ordy[d] = 1'b1;
        @(posedge clk); #1;
        ordy[d] = 1'b0;
        check("out_valid_clear", 128'(ov[d]), 128'd0);
        check("in_ready_rise", 128'(iry[d]), 128'd1);
    endtask

    initial begin
        logic [127:0] res;
        logic [127:0] mid;
        logic [127:0] orig;
        int lat;
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            iv[i] = 1'b0; idat[i] = '0; im[i] = 1'b0; ordy[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("rst_in_ready", 128'(iry[i]), 128'd1);
            check("rst_out_valid", 128'(ov[i]), 128'd0);
            check("rst_busy", 128'(bsy[i]), 128'd0);
            check("rst_out_data", od[i], 128'd0);
        end

        run_block(0, V1_IN, 1'b0, 4, res);
        check("fwd_c1", res, V1_OUT);
        run_block(2, FIPS_IN, 1'b0, 1, res);
        check("fwd_c4_fips", res, FIPS_OUT);
        run_block(1, V1_OUT, 1'b1, 2, res);
        check("inv_c2", res, V1_IN);
        run_block(2, FIPS_OUT, 1'b1, 1, res);
        check("inv_c4_fips", res, FIPS_IN);
        run_block(3, D4_IN, 1'b1, 4, res);
        check("fwd_only_mode_ignored", res, D4_OUT);

        for (int k = 0; k < 100; k++) begin
            orig = {$urandom, $urandom, $urandom, $urandom};
            run_block(1, orig, 1'b0, 2, mid);
            run_block(1, mid, 1'b1, 2, res);
            check("round_trip", res, orig);
        end

        // Backpressure: result held in DONE while a competing request is offered.
        @(negedge clk);
        idat[0] = FIPS_IN; im[0] = 1'b0; iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        lat = 0;
        while (!ov[0] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp_latency", 128'(lat), 128'd4);
        @(negedge clk);
        idat[0] = V1_IN; im[0] = 1'b1; iv[0] = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            check("bp_out_data", od[0], FIPS_OUT);
            check("bp_out_valid", 128'(ov[0]), 128'd1);
            check("bp_in_ready", 128'(iry[0]), 128'd0);
        end
        @(negedge clk);
        iv[0] = 1'b0; ordy[0] = 1'b1;
        @(posedge clk); #1;
        ordy[0] = 1'b0;
        check("bp_in_ready_rise", 128'(iry[0]), 128'd1);
        run_block(0, V1_IN, 1'b0, 4, res);
        check("bp_next_block", res, V1_OUT);

        // Reset during the second BUSY cycle discards the block.
        @(negedge clk);
        idat[0] = V1_IN; im[0] = 1'b0; iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        @(posedge clk); #1;
        check("mid_busy", 128'(bsy[0]), 128'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mr_out_valid", 128'(ov[0]), 128'd0);
        check("mr_out_data", od[0], 128'd0);
        check("mr_busy", 128'(bsy[0]), 128'd0);
        check("mr_in_ready", 128'(iry[0]), 128'd1);
        repeat (8) begin
            @(posedge clk); #1;
            check("mr_no_stale", 128'(ov[0]), 128'd0);
        end
        run_block(0, FIPS_IN, 1'b0, 4, res);
        check("mr_after_reset", res, FIPS_OUT);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mix_columns_seq.md
Name: mix_columns_seq

Overview:
- Sequential, parametrised MixColumns engine for the AES round datapath.
- Accepts a full 128-bit state over a valid/ready handshake and transforms it in place, COLS_PER_CYCLE columns per clock.
- Supports forward MixColumns and, when enabled, InvMixColumns, selected per block.
- Presents the result on a valid/ready output held until consumed; sits between ShiftRows/InvShiftRows and AddRoundKey.

Parameters:
- COLS_PER_CYCLE, 1, columns transformed per BUSY cycle; legal values 1, 2, 4.
- INV_EN, 1, 1 = inverse mode implemented; 0 = mode input ignored, forward only.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data/in_mode valid.
- in_ready  output  1  block can accept; high only in IDLE.
- in_data  input  128  state; column c = bits [127-32c -: 32], byte r of column = bits [31-8r -: 8] within it.
- in_mode  input  1  0 = MixColumns, 1 = InvMixColumns (forced 0 when INV_EN=0).
- out_valid  output  1  out_data holds a completed result.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  128  transformed state, same byte layout as in_data.
- busy  output  1  high in BUSY or DONE.

Behaviour:
- Reset (sync, highest priority, any state incl. mid-block): state=IDLE, col counter=0, out_valid=0, out_data=0, busy=0, in_ready=1 on the following cycle. An in-flight block is discarded.
- FSM IDLE -> BUSY -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_data into the working register and latch mode; counter=0; go to BUSY.
- BUSY:
  - Each cycle, columns counter..counter+COLS_PER_CYCLE-1 are replaced by their transform; counter += COLS_PER_CYCLE.
  - After the group containing column 3, go to DONE with out_valid=1.
  - Inputs are ignored (in_ready=0).
- DONE:
  - out_valid=1, out_data = working register, stable until handshake.
  - On out_ready: out_valid=0, go to IDLE.
  - No same-cycle re-accept; in_ready rises the cycle after the output handshake.
- Latency: out_valid rises 4/COLS_PER_CYCLE cycles after the accepting edge. Minimum initiation interval is 4/COLS_PER_CYCLE + 2 cycles.
- out_ready while out_valid=0 has no effect. in_valid may drop without ever being accepted.
- Forward column transform, over GF(2^8) with reduction polynomial 0x11B; xtime(b) = (b<<1) ^ (b[7] ? 0x1B : 0):
  - b0' = 2a0^3a1^a2^a3
  - b1' = a0^2a1^3a2^a3
  - b2' = a0^a1^2a2^3a3
  - b3' = 3a0^a1^a2^2a3
- Inverse column transform: the same structure with coefficients 0e,0b,0d,09 (row 0: 0e 0b 0d 09, rotated right by one per row). Build the products from chained xtime, not generic multipliers.
- Mode is latched at acceptance; changes to in_mode during BUSY/DONE have no effect.
- The counter wraps to 0 on entry to DONE. Out-of-range parameter values are an elaboration error.

Test Plan:
- Forward, COLS_PER_CYCLE=1, in_data = db135345_f20a225c_01010101_c6c6c6c6 -> out_data = 8e4da1bc_9fdc589d_01010101_c6c6c6c6; out_valid exactly 4 cycles after acceptance.
- Forward, COLS_PER_CYCLE=4, in_data = d4bf5d30_e0b452ae_b84111f1_1e2798e5 (FIPS-197 round 1) -> out_data = 046681e5_e0cb199a_48f8d37a_2806264c; latency 1 cycle.
- Inverse, COLS_PER_CYCLE=2, in_mode=1, in_data = 8e4da1bc_9fdc589d_01010101_c6c6c6c6 -> db135345_f20a225c_01010101_c6c6c6c6; latency 2 cycles. Also check round-trip forward then inverse on 100 random states returns the original.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_data stable, in_ready=0, new in_valid ignored. Raise out_ready -> in_ready=1 the next cycle, and the next block is accepted correctly.
- Reset mid-block: assert reset in the 2nd BUSY cycle (COLS_PER_CYCLE=1) -> the next cycle shows out_valid=0, out_data=0, busy=0, in_ready=1. No stale result appears afterwards.
- INV_EN=0 with in_mode=1, input d4d4d4d5 in all columns -> forward result d5d5d7d6 in every column.
